fft_mem_seq: RTL and testbench
==============================

FFT_MEM_SEQ -- requirements
Module: fft_mem_seq

Interface
REQ-001 Parameter DW, default fft_consts::DW, RAM word width (opaque packed complex sample).
REQ-002 Parameter N, default fft_consts::N, transform length, power of two >= 4; LOGN = $clog2(N).
REQ-003 clk  in  1  sole clock; all state on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  begin one full in-place radix-2 DIF pass; sampled only in IDLE.
REQ-006 busy  out  1  high from the cycle after accepted start through the final write cycle.
REQ-007 done  out  1  one-cycle pulse after the final write.
REQ-008 ena, wea  out  1 each  RAM port A enable / write enable.
REQ-009 addra  out  LOGN  port A address. dina  out  DW  port A write data. douta  in  DW  port A read data.
REQ-010 enb, web, addrb, dinb, doutb: port B equivalents, same widths and directions.
REQ-011 bf_valid  out  1, bf_ready  in  1, bf_x0/bf_x1  out  DW, bf_tw  out  LOGN-1: operand pair and twiddle index to butterfly.
REQ-012 res_valid  in  1, res_ready  out  1, res_y0/res_y1  in  DW: butterfly results.

Function
REQ-013 The block SHALL act as initiator on a dual-port RAM with one-cycle registered read latency (dout valid in the cycle after en with we=0).
REQ-014 States SHALL be IDLE, RD, CAP, BF, RES, WR; IDLE->RD on start; RD->CAP->BF unconditionally; BF->RES on bf_valid&&bf_ready; RES->WR on res_valid&&res_ready; WR->RD if butterflies remain, else IDLE.
REQ-015 Counters: stage s in 0..LOGN-1, butterfly k in 0..N/2-1; span = N>>(s+1); j = k mod span; addr0 = (k/span)*2*span + j; addr1 = addr0 + span; tw = j<<s.
REQ-016 RD: ena=enb=1, wea=web=0, addra=addr0, addrb=addr1; all other cycles outside RD/WR: ena=enb=wea=web=0.
REQ-017 CAP: douta/doutb SHALL be registered into bf_x0/bf_x1; tw registered into bf_tw.
REQ-018 BF: bf_valid=1 with x0/x1/tw stable until handshake; bf_valid=0 in every other state.
REQ-019 RES: res_ready=1; y0/y1 captured on handshake; res_ready=0 in every other state.
REQ-020 WR: ena=wea=1, addra=addr0, dina=y0; enb=web=1, addrb=addr1, dinb=y1; addresses always differ, no port collision.
REQ-021 WR advances k; k wrap to 0 increments s; WR at s=LOGN-1, k=N/2-1 SHALL go to IDLE and assert done next cycle.
REQ-022 start while busy SHALL be ignored; start in the same cycle as done SHALL be accepted (new pass).
REQ-023 Backpressure: bf_ready or res_valid held low for any number of cycles SHALL stall in BF/RES with no RAM access.

Reset
REQ-024 rst SHALL force IDLE, s=k=0, busy=done=0, all RAM enables/write enables 0, bf_valid=res_ready=0, data/address registers 0, immediately (no clock).
REQ-025 rst mid-pass SHALL abort without further RAM writes; a subsequent start SHALL restart from s=0, k=0.

Verification
REQ-026 N=8, bf_ready=res_valid=1 constant, pulse start -> RD at 0/4 tw0; k=3 RD 3/7 tw3; stage1 k=2 RD 4/6 tw0; stage2 k=3 RD 6/7 tw0; 12 butterflies x 5 cycles, done 60 cycles after first RD.
REQ-027 Preload RAM[0]=A, RAM[4]=B, butterfly model y0=x0+x1, y1=x0-x1 -> bf_x0=A, bf_x1=B in first BF cycle; WR writes A+B to 0, A-B to 4.
REQ-028 Hold bf_ready=0 for 7 cycles, res_valid=0 for 3 cycles -> bf_valid/x0/x1/tw stable 7 cycles, no en asserted during stalls, pass length +10 cycles.
REQ-029 Assert rst during a WR cycle -> enables, busy, bf_valid drop same cycle; no write on next edge; new start reads 0/4.
REQ-030 Pulse start while busy and again coincident with done -> first ignored (no address restart), second begins new pass at 0/4 next cycle.
REQ-031 Full-pass check vs reference DIF FFT model on random input -> RAM contents match bit-reversed reference output exactly.

Source files
------------

// File: rtl/fft_mem_seq.sv
// In-place radix-2 DIF memory sequencer: walks every butterfly of every stage, reads the operand
// pair from a dual-port RAM, hands it to an external butterfly and writes the results back.
package fft_consts;
    localparam int DW = 32;
    localparam int N  = 8;
endpackage

module fft_mem_seq #(
    parameter int DW    = fft_consts::DW,
    parameter int N     = fft_consts::N,
    localparam int LOGN = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            ena_o,
    output logic            wea_o,
    output logic [LOGN-1:0] addra_o,
    output logic [DW-1:0]   dina_o,
    input  logic [DW-1:0]   douta_i,
    output logic            enb_o,
    output logic            web_o,
    output logic [LOGN-1:0] addrb_o,
    output logic [DW-1:0]   dinb_o,
    input  logic [DW-1:0]   doutb_i,
    output logic            bf_valid_o,
    input  logic            bf_ready_i,
    output logic [DW-1:0]   bf_x0_o,
    output logic [DW-1:0]   bf_x1_o,
    output logic [LOGN-2:0] bf_tw_o,
    input  logic            res_valid_i,
    output logic            res_ready_o,
    input  logic [DW-1:0]   res_y0_i,
    input  logic [DW-1:0]   res_y1_i
);

    typedef enum logic [2:0] {IDLE, RD, CAP, BF, RES, WR} state_t;

    state_t          state_q, state_d;
    logic [LOGN-1:0] s_q, s_d;
    logic [LOGN-2:0] k_q, k_d;
    logic [DW-1:0]   x0_q, x0_d, x1_q, x1_d;
    logic [DW-1:0]   y0_q, y0_d, y1_q, y1_d;
    logic [LOGN-2:0] tw_q, tw_d;
    logic            done_q, done_d;

    logic [LOGN-1:0] span, j, addr0, addr1;
    logic [LOGN-2:0] tw;

    // span is a power of two, so k/span and the 2*span block stride reduce to shifts
    always_comb begin
        span  = LOGN'(N >> (s_q + LOGN'(1)));
        j     = {1'b0, k_q} & (span - LOGN'(1));
        addr0 = (({1'b0, k_q} >> (LOGN - 1 - int'(s_q))) << (LOGN - int'(s_q))) | j;
        addr1 = addr0 | span;
        tw    = j[LOGN-2:0] << s_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            tw_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            tw_q    <= tw_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        k_d         = k_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y0_d        = y0_q;
        y1_d        = y1_q;
        tw_d        = tw_q;
        done_d      = 1'b0;
        ena_o       = 1'b0;
        enb_o       = 1'b0;
        wea_o       = 1'b0;
        web_o       = 1'b0;
        addra_o     = '0;
        addrb_o     = '0;
        bf_valid_o  = 1'b0;
        res_ready_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = RD;
            end
            RD: begin
                ena_o   = 1'b1;
                enb_o   = 1'b1;
                addra_o = addr0;
                addrb_o = addr1;
                state_d = CAP;
            end
            CAP: begin
                x0_d    = douta_i;
                x1_d    = doutb_i;
                tw_d    = tw;
                state_d = BF;
            end
            BF: begin
                bf_valid_o = 1'b1;
                if (bf_ready_i) state_d = RES;
            end
            RES: begin
                res_ready_o = 1'b1;
                if (res_valid_i) begin
                    y0_d    = res_y0_i;
                    y1_d    = res_y1_i;
                    state_d = WR;
                end
            end
            WR: begin
                ena_o   = 1'b1;
                wea_o   = 1'b1;
                enb_o   = 1'b1;
                web_o   = 1'b1;
                addra_o = addr0;
                addrb_o = addr1;
                if (k_q == '1) begin
                    k_d = '0;
                    if (s_q == LOGN'(LOGN - 1)) begin
                        s_d     = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d     = s_q + LOGN'(1);
                        state_d = RD;
                    end
                end else begin
                    k_d     = k_q + (LOGN-1)'(1);
                    state_d = RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign dina_o  = y0_q;
    assign dinb_o  = y1_q;
    assign bf_x0_o = x0_q;
    assign bf_x1_o = x1_q;
    assign bf_tw_o = tw_q;

endmodule

// File: tb/tb_fft_mem_seq.sv
// Bench for fft_mem_seq: dual-port RAM model, number-theoretic butterfly (mod 65537) and a
// direct-DFT reference, so a correct pass leaves the bit-reversed transform in RAM.
module tb_fft_mem_seq;

    localparam int     DW   = 32;
    localparam int     N    = 8;
    localparam int     LOGN = $clog2(N);
    localparam int     NB   = (N / 2) * LOGN;
    localparam longint P    = 65537;

    logic            clk_i;
    logic            rst_i = 1'b1;
    logic            start_i = 1'b0;
    logic            busy_o, done_o;
    logic            ena_o, wea_o, enb_o, web_o;
    logic [LOGN-1:0] addra_o, addrb_o;
    logic [DW-1:0]   dina_o, dinb_o, douta_i, doutb_i;
    logic            bf_valid_o, bf_ready_i;
    logic [DW-1:0]   bf_x0_o, bf_x1_o;
    logic [LOGN-2:0] bf_tw_o;
    logic            res_valid_i, res_ready_o;
    logic [DW-1:0]   res_y0_i, res_y1_i;

    fft_mem_seq #(.DW(DW), .N(N)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .ena_o(ena_o), .wea_o(wea_o), .addra_o(addra_o), .dina_o(dina_o), .douta_i(douta_i),
        .enb_o(enb_o), .web_o(web_o), .addrb_o(addrb_o), .dinb_o(dinb_o), .doutb_i(doutb_i),
        .bf_valid_o(bf_valid_o), .bf_ready_i(bf_ready_i), .bf_x0_o(bf_x0_o), .bf_x1_o(bf_x1_o),
        .bf_tw_o(bf_tw_o), .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
        .res_y0_i(res_y0_i), .res_y1_i(res_y1_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    longint cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic longint modpow(longint b, int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % P;
        return r;
    endfunction

    function automatic int bitrev(int v);
        int r = 0;
        for (int i = 0; i < LOGN; i++)
            if (((v >> i) & 1) != 0) r = r | (1 << (LOGN - 1 - i));
        return r;
    endfunction

    longint W = 1;

    // RAM model: one-cycle registered read, bulk preload only while the sequencer is idle
    logic [DW-1:0] mem [N];
    logic [DW-1:0] init_mem [N];
    logic          load_req = 1'b0;
    int            ram_wr_cnt = 0;

    always @(posedge clk_i) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) mem[i] <= init_mem[i];
        end else begin
            if (ena_o) begin
                if (wea_o) mem[addra_o] <= dina_o;
                douta_i <= mem[addra_o];
            end
            if (enb_o) begin
                if (web_o) mem[addrb_o] <= dinb_o;
                doutb_i <= mem[addrb_o];
            end
            if ((ena_o && wea_o) || (enb_o && web_o)) ram_wr_cnt <= ram_wr_cnt + 1;
        end
    end

    // Butterfly responder with per-butterfly stall tables
    int            bf_stall_tab [NB] = '{default: 0};
    int            res_stall_tab [NB] = '{default: 0};
    int            bf_idx = 0, res_idx = 0, bf_wait = 0, res_wait = 0;
    logic [DW-1:0] y0_r = '0, y1_r = '0;

    assign bf_ready_i  = (bf_wait >= ((bf_idx < NB) ? bf_stall_tab[bf_idx] : 0));
    assign res_valid_i = (res_wait >= ((res_idx < NB) ? res_stall_tab[res_idx] : 0));
    assign res_y0_i    = y0_r;
    assign res_y1_i    = y1_r;

    always @(posedge clk_i) begin
        if (rst_i || done_o) begin
            bf_idx <= 0; res_idx <= 0; bf_wait <= 0; res_wait <= 0;
        end else begin
            if (bf_valid_o) begin
                if (bf_ready_i) begin
                    y0_r    <= DW'((longint'(bf_x0_o) + longint'(bf_x1_o)) % P);
                    y1_r    <= DW'((((longint'(bf_x0_o) - longint'(bf_x1_o) + P) % P)
                                    * modpow(W, int'(bf_tw_o))) % P);
                    bf_idx  <= bf_idx + 1;
                    bf_wait <= 0;
                end else bf_wait <= bf_wait + 1;
            end
            if (res_ready_o) begin
                if (res_valid_i) begin
                    res_idx  <= res_idx + 1;
                    res_wait <= 0;
                end else res_wait <= res_wait + 1;
            end
        end
    end

    // Event monitor, sampled away from the active edge
    typedef struct { longint cyc; longint a; longint b; longint d0; longint d1; } ev_t;
    ev_t rd_q[$], bf_q[$], wr_q[$];
    int  en_viol = 0, bf_unstable = 0, bf_vcyc = 0;
    logic            pv_valid = 1'b0, pv_hs = 1'b0;
    logic [DW-1:0]   pv_x0 = '0, pv_x1 = '0;
    logic [LOGN-2:0] pv_tw = '0;

    function automatic ev_t mk_ev(longint c, longint a, longint b, longint d0, longint d1);
        ev_t e;
        e.cyc = c; e.a = a; e.b = b; e.d0 = d0; e.d1 = d1;
        return e;
    endfunction

    always @(negedge clk_i) begin
        if (ena_o && !wea_o) rd_q.push_back(mk_ev(cyc, addra_o, addrb_o, 0, 0));
        if (bf_valid_o && bf_ready_i) bf_q.push_back(mk_ev(cyc, bf_tw_o, 0, bf_x0_o, bf_x1_o));
        if (ena_o && wea_o) wr_q.push_back(mk_ev(cyc, addra_o, addrb_o, dina_o, dinb_o));
        if ((bf_valid_o || res_ready_o) && (ena_o || enb_o)) en_viol <= en_viol + 1;
        if (bf_valid_o) bf_vcyc <= bf_vcyc + 1;
        if (bf_valid_o && pv_valid && !pv_hs &&
            (bf_x0_o != pv_x0 || bf_x1_o != pv_x1 || bf_tw_o != pv_tw))
            bf_unstable <= bf_unstable + 1;
        pv_valid <= bf_valid_o;
        pv_hs    <= bf_valid_o && bf_ready_i;
        pv_x0    <= bf_x0_o;
        pv_x1    <= bf_x1_o;
        pv_tw    <= bf_tw_o;
    end

    // Expected butterfly order from the textbook DIF loop nest
    int     exp_a0 [NB], exp_a1 [NB], exp_tw [NB];
    longint ref_in [N];
    int     base_rd, base_bf, base_wr, bfv0;

    task automatic fill_rand();
        for (int i = 0; i < N; i++) init_mem[i] = DW'($urandom_range(0, int'(P - 1)));
    endtask

    task automatic load_ram();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic run_pass(input bit do_start, input int poke_at, input bit chain, input int exp_len);
        longint x, dcyc;
        int     en0, un0;
        bit     seen;
        base_rd = rd_q.size(); base_bf = bf_q.size(); base_wr = wr_q.size();
        en0 = en_viol; un0 = bf_unstable; bfv0 = bf_vcyc;
        for (int i = 0; i < N; i++) ref_in[i] = longint'(mem[i]);
        if (do_start) begin
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
        end
        seen = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            start_i = (i == poke_at);
            tick();
            if (done_o) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        start_i = 1'b0;
        chk("done_seen", seen, 1);
        chk("busy_at_done", busy_o, 0);
        chk("rd_count", rd_q.size() - base_rd, NB);
        chk("wr_count", wr_q.size() - base_wr, NB);
        chk("bf_count", bf_q.size() - base_bf, NB);
        for (int i = 0; i < NB; i++) begin
            if (base_rd + i < rd_q.size()) begin
                chk("rd_addra", rd_q[base_rd + i].a, exp_a0[i]);
                chk("rd_addrb", rd_q[base_rd + i].b, exp_a1[i]);
            end
            if (base_wr + i < wr_q.size()) begin
                chk("wr_addra", wr_q[base_wr + i].a, exp_a0[i]);
                chk("wr_addrb", wr_q[base_wr + i].b, exp_a1[i]);
            end
            if (base_bf + i < bf_q.size()) chk("bf_tw", bf_q[base_bf + i].a, exp_tw[i]);
        end
        if (rd_q.size() > base_rd) chk("pass_len", dcyc - rd_q[base_rd].cyc, exp_len);
        chk("en_in_stall", en_viol - en0, 0);
        chk("bf_stable", bf_unstable - un0, 0);
        for (int k = 0; k < N; k++) begin
            x = 0;
            for (int n = 0; n < N; n++) x = (x + ref_in[n] * modpow(W, (n * k) % N)) % P;
            chk("ram_result", longint'(mem[bitrev(k)]), x);
        end
        if (chain) begin
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
        end
    endtask

    initial begin
        int nb, a_val, b_val, w0, nw;
        W = modpow(3, int'((P - 1) / N));
        nb = 0;
        for (int s = 0; s < LOGN; s++) begin
            int span;
            span = N >> (s + 1);
            for (int base = 0; base < N; base += 2 * span)
                for (int j = 0; j < span; j++) begin
                    exp_a0[nb] = base + j;
                    exp_a1[nb] = base + j + span;
                    exp_tw[nb] = j << s;
                    nb++;
                end
        end

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_en", {ena_o, enb_o, wea_o, web_o}, 0);
        chk("rst_hs", {bf_valid_o, res_ready_o}, 0);
        chk("rst_addr", {addra_o, addrb_o}, 0);
        chk("rst_data", {bf_x0_o, bf_x1_o}, 0);
        rst_i = 1'b0;
        tick();

        // nominal pass with known pair at 0/4
        fill_rand();
        a_val = int'(init_mem[0]);
        b_val = int'(init_mem[4]);
        load_ram();
        run_pass(1'b1, -1, 1'b0, 60);
        if (bf_q.size() > base_bf && rd_q.size() > base_rd) begin
            chk("bf0_x0", bf_q[base_bf].d0, a_val);
            chk("bf0_x1", bf_q[base_bf].d1, b_val);
            chk("bf0_lat", bf_q[base_bf].cyc - rd_q[base_rd].cyc, 2);
        end
        if (wr_q.size() > base_wr) begin
            chk("wr0_y0", wr_q[base_wr].d0, (a_val + b_val) % P);
            chk("wr0_y1", wr_q[base_wr].d1, (a_val - b_val + P) % P);
        end
        tick();
        chk("done_pulse", done_o, 0);

        // backpressure on the first butterfly
        bf_stall_tab[0]  = 7;
        res_stall_tab[0] = 3;
        fill_rand();
        load_ram();
        run_pass(1'b1, -1, 1'b0, 70);
        if (bf_q.size() > base_bf && rd_q.size() > base_rd)
            chk("stall_bf_hs", bf_q[base_bf].cyc - rd_q[base_rd].cyc, 9);
        if (wr_q.size() > base_wr && rd_q.size() > base_rd)
            chk("stall_wr0", wr_q[base_wr].cyc - rd_q[base_rd].cyc, 14);
        chk("stall_bf_cycles", bf_vcyc - bfv0, NB + 7);
        bf_stall_tab[0]  = 0;
        res_stall_tab[0] = 0;
        tick();

        // reset during the third write cycle
        fill_rand();
        load_ram();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        nw = 0;
        for (int i = 0; i < 200 && nw < 3; i++) begin
            tick();
            if (ena_o && wea_o) nw++;
        end
        chk("rst_wr_found", nw, 3);
        w0 = ram_wr_cnt;
        rst_i = 1'b1;
        #1;
        chk("rst_async_en", {ena_o, enb_o, wea_o, web_o}, 0);
        chk("rst_async_busy", {busy_o, bf_valid_o, res_ready_o}, 0);
        tick();
        chk("rst_no_write", ram_wr_cnt - w0, 0);
        rst_i = 1'b0;
        tick();
        fill_rand();
        load_ram();
        run_pass(1'b1, -1, 1'b0, 60);
        tick();

        // start while busy is ignored; start coincident with done chains a new pass
        fill_rand();
        load_ram();
        run_pass(1'b1, 10, 1'b1, 60);
        chk("chain_rd", (ena_o && !wea_o), 1);
        chk("chain_addra", addra_o, 0);
        chk("chain_addrb", addrb_o, 4);
        chk("chain_busy", busy_o, 1);
        run_pass(1'b0, -1, 1'b0, 60);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
